// File: rtl/gpu_prim_pkg.sv
// gpu_prim_pkg: geometry type codes, assembled-primitive codes and FIFO entry layout
package gpu_prim_pkg;
    typedef enum logic [3:0] {
        PT_POINTS     = 4'd0,
        PT_LINES      = 4'd1,
        PT_LINE_STRIP = 4'd2,
        PT_TRIANGLES  = 4'd3,
        PT_TRI_STRIP  = 4'd4,
        PT_TRI_FAN    = 4'd5
    } prim_type_e;

    localparam logic [1:0] OT_POINT = 2'd0;
    localparam logic [1:0] OT_LINE  = 2'd1;
    localparam logic [1:0] OT_TRI   = 2'd2;

    // {type[1:0], V0, V1, V2}
    localparam int ENTRY_W = 98;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISCARD} asm_state_e;

    function automatic logic type_valid(input logic [3:0] t);
        return t <= 4'd5;
    endfunction

    function automatic logic [1:0] out_type(input prim_type_e t);
        return (t == PT_POINTS) ? OT_POINT :
               (t == PT_LINES || t == PT_LINE_STRIP) ? OT_LINE : OT_TRI;
    endfunction
endpackage

// File: rtl/primitive_assembler_fifo.sv
// prim_fifo: synchronous show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop
module prim_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 98
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] level_q, level_d;
    logic wr_en, rd_en;

    assign full  = level_q == (AW+1)'(DEPTH);
    assign empty = level_q == '0;
    assign level = level_q;
    // head is masked while empty so the outputs read 0 instead of stale or uninitialised storage
    assign dout  = empty ? '0 : mem_q[rd_q];

    always_comb begin
        rd_en   = pop && !empty;
        wr_en   = push && (!full || rd_en);
        wr_d    = wr_q + AW'(wr_en);
        rd_d    = rd_q + AW'(rd_en);
        level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/primitive_assembler.sv
// primitive_assembler: groups decoded vertices into points/lines/triangles and drains them to the rasteriser
module primitive_assembler
    import gpu_prim_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               StartPrimitive,
    input  logic [3:0]         PrimitiveType,
    input  logic               NewVertex,
    input  logic [31:0]        Vertex,
    input  logic               EndPrimitive,
    input  logic               Draw,
    input  logic               Prim_Ready,
    output logic               Prim_Valid,
    output logic [1:0]         Prim_Type,
    output logic [31:0]        Prim_V0,
    output logic [31:0]        Prim_V1,
    output logic [31:0]        Prim_V2,
    output logic [FIFO_AW:0]   Fifo_Level,
    output logic               Collecting,
    output logic               Overflow,
    output logic               Bad_Type
);
    asm_state_e state_q, state_d;
    prim_type_e type_q, type_d;
    logic [1:0] vcnt_q, vcnt_d;
    logic odd_q, odd_d, drain_q, drain_d, overflow_q, overflow_d, bad_q, bad_d;
    logic [31:0] a_q, a_d, p1_q, p1_d, p0_q, p0_d;
    logic start, endp, nv, draw, tv, push, pop, full, empty;
    logic [31:0] v0, v1, v2;
    logic [ENTRY_W-1:0] head;

    // strobe priority: Start > End > NewVertex > Draw
    assign start = StartPrimitive;
    assign endp  = !start && EndPrimitive;
    assign nv    = !start && !EndPrimitive && NewVertex;
    assign draw  = !start && !EndPrimitive && !NewVertex && Draw;
    assign tv    = start && type_valid(PrimitiveType);

    assign Prim_Valid = drain_q && !empty;
    assign pop        = Prim_Valid && Prim_Ready;
    assign {Prim_Type, Prim_V0, Prim_V1, Prim_V2} = head;
    assign Collecting = state_q == S_COLLECT;
    assign Overflow   = overflow_q;
    assign Bad_Type   = bad_q;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        vcnt_d  = vcnt_q;
        odd_d   = odd_q;
        a_d     = a_q;
        p1_d    = p1_q;
        p0_d    = p0_q;
        bad_d   = bad_q;
        push    = 1'b0;
        v0      = '0;
        v1      = '0;
        v2      = '0;
        if (start) begin
            state_d = tv ? S_COLLECT : S_DISCARD;
            type_d  = tv ? prim_type_e'(PrimitiveType) : type_q;
            bad_d   = bad_q | !tv;
            vcnt_d  = '0;
            odd_d   = 1'b0;
        end else if (endp) begin
            state_d = S_IDLE;
        end else if (nv && state_q == S_COLLECT) begin
            a_d    = (vcnt_q == 2'd0) ? Vertex : a_q;
            p0_d   = p1_q;
            p1_d   = Vertex;
            vcnt_d = (vcnt_q == 2'd3) ? vcnt_q : vcnt_q + 2'd1;
            case (type_q)
                PT_POINTS: begin
                    push = 1'b1;
                    v0   = Vertex;
                end
                PT_LINES, PT_LINE_STRIP: begin
                    push = (type_q == PT_LINES) ? vcnt_q == 2'd1 : vcnt_q != 2'd0;
                    v0   = p1_q;
                    v1   = Vertex;
                    vcnt_d = (type_q == PT_LINES && push) ? 2'd0 : vcnt_d;
                end
                PT_TRIANGLES: begin
                    push   = vcnt_q == 2'd2;
                    v0     = p0_q;
                    v1     = p1_q;
                    v2     = Vertex;
                    vcnt_d = push ? 2'd0 : vcnt_d;
                end
                PT_TRI_STRIP: begin
                    push  = vcnt_q >= 2'd2;
                    v0    = odd_q ? p1_q : p0_q;
                    v1    = odd_q ? p0_q : p1_q;
                    v2    = Vertex;
                    odd_d = odd_q ^ push;
                end
                PT_TRI_FAN: begin
                    push = vcnt_q >= 2'd2;
                    v0   = a_q;
                    v1   = p1_q;
                    v2   = Vertex;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        drain_d    = drain_q ? !(pop && Fifo_Level == (FIFO_AW+1)'(1) && !push) : draw;
        overflow_d = overflow_q | (push && full && !pop);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            type_q     <= PT_POINTS;
            vcnt_q     <= '0;
            odd_q      <= 1'b0;
            a_q        <= '0;
            p1_q       <= '0;
            p0_q       <= '0;
            drain_q    <= 1'b0;
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            vcnt_q     <= vcnt_d;
            odd_q      <= odd_d;
            a_q        <= a_d;
            p1_q       <= p1_d;
            p0_q       <= p0_d;
            drain_q    <= drain_d;
            overflow_q <= overflow_d;
            bad_q      <= bad_d;
        end
    end

    prim_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .W(ENTRY_W)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .din   ({out_type(type_q), v0, v1, v2}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (Fifo_Level)
    );
endmodule

// File: doc/primitive_assembler.md
Name: primitive_assembler

Overview:
- Consumes the decode stage's geometry strobes (StartPrimitive/PrimitiveType, NewVertex/Vertex, EndPrimitive, Draw).
- Groups vertices into points, lines or triangles and queues completed primitives in an internal FIFO.
- After a Draw, drains the FIFO to the rasteriser over a valid/ready handshake.
- Sits between instruction decode and the raster front-end; it is the receiving end of the decoder's geometry interface.

Parameters:
- FIFO_DEPTH, 8, number of queued primitives; power of two, ≥2.
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- CLK  in  1  clock
- RESET  in  1  reset
- StartPrimitive  in  1  one-cycle strobe; opens a primitive group
- PrimitiveType  in  4  group type; valid only with StartPrimitive
- NewVertex  in  1  one-cycle strobe; Vertex is valid
- Vertex  in  32  [15:0]=X, [31:16]=Y; valid only with NewVertex
- EndPrimitive  in  1  one-cycle strobe; closes the group
- Draw  in  1  one-cycle strobe; starts the drain
- Prim_Ready  in  1  rasteriser accepts
- Prim_Valid  out  1  primitive presented
- Prim_Type  out  2  0=point, 1=line, 2=triangle
- Prim_V0, Prim_V1, Prim_V2  out  32 each  vertices; unused slots are 0
- Fifo_Level  out  FIFO_AW+1  queued entries
- Collecting  out  1  a group is open
- Overflow  out  1  sticky; a primitive was dropped because the FIFO was full
- Bad_Type  out  1  sticky; an unsupported PrimitiveType was received

Behaviour:
- RESET is asynchronous, active-high; clock is CLK, all state on posedge.
- Reset values: every output 0; FIFO empty; assembler in IDLE; drain inactive.
- Type codes: 0 POINTS, 1 LINES, 2 LINE_STRIP, 3 TRIANGLES, 4 TRI_STRIP, 5 TRI_FAN. Codes 6-15 are invalid.
- Vertex and PrimitiveType are X except while their strobe is high; never sample them otherwise.
- At most one strobe is high per cycle. If several are high, priority is StartPrimitive > EndPrimitive > NewVertex > Draw; the losers are ignored.

Assembler FSM (IDLE, COLLECT, DISCARD):
- IDLE, StartPrimitive with valid type: go to COLLECT; latch type; vcnt=0; odd=0.
- IDLE, StartPrimitive with invalid type: set Bad_Type; go to DISCARD.
- COLLECT or DISCARD, StartPrimitive: implicit end of the current group (partial vertices dropped), then treat as a new StartPrimitive.
- COLLECT or DISCARD, EndPrimitive: go to IDLE; drop partial vertices.
- IDLE, NewVertex or EndPrimitive: ignored.
- DISCARD, NewVertex: ignored.
- Collecting = (state==COLLECT).
- Vertex history registers: A (first vertex of group), P1 (previous), P0 (older). vcnt saturates at 3.

Per NewVertex N in COLLECT (push happens on the same posedge):
- POINTS: push (N).
- LINES: first vertex of a pair stored in P1; second pushes (P1,N); pairing restarts.
- LINE_STRIP: from the 2nd vertex on, push (P1,N).
- TRIANGLES: collect 3, push (P0,P1,N), restart.
- TRI_STRIP: from the 3rd vertex on, push (P0,P1,N) when odd=0 and (P1,P0,N) when odd=1; toggle odd after each push.
- TRI_FAN: from the 3rd vertex on, push (A,P1,N).

FIFO:
- Entry is {type[1:0], V0, V1, V2}. Show-ahead: head drives the Prim_* outputs combinationally.
- Pop when Prim_Valid && Prim_Ready.
- Push when full without a same-cycle pop: entry dropped, Overflow set. Push when full with a same-cycle pop: accepted.
- Fifo_Level is updated on the edge of the push/pop.
- Sticky flags clear only on RESET.

Drain:
- Draw sets drain_active. Draw while already active has no effect.
- Prim_Valid = drain_active && !empty.
- drain_active clears on the edge where the last entry pops and no push occurs that cycle.
- Primitives pushed while draining are also drained.
- While Prim_Valid is high and Prim_Ready is low, the Prim_* outputs hold stable.
- Latency: the primitive-completing NewVertex at edge k gives Prim_Valid at cycle k+1 if drain_active (1-cycle).
- RESET mid-drain or mid-group: FIFO flushed immediately, Prim_Valid drops asynchronously.

Decomposition:
- Package gpu_prim_pkg holds the PrimitiveType codes, output Prim_Type codes and the FIFO entry width constant (98). The team's instruction-set decode will share these type codes.
- Sub-module prim_fifo: a parameterised synchronous show-ahead FIFO with full/empty/level outputs.

Test Plan:
- Start(TRIANGLES); vertices 0x00010001, 0x00020002, 0x00030003; End; Draw; Ready=1 -> one Prim_Valid cycle, type 2, V0..V2 in that order; Fifo_Level 1->0.
- Start(TRI_STRIP); 5 vertices a,b,c,d,e; Draw -> (a,b,c), (c,b,d), (c,d,e).
- Start(TRI_FAN) a,b,c,d, then Start(LINE_STRIP) a,b,c -> fan (a,b,c),(a,c,d); strip (a,b),(b,c).
- Start(POINTS); 10 vertices with no Draw, FIFO_DEPTH 8 -> Fifo_Level 8, Overflow=1; Draw with Ready=1 -> exactly 8 points, first 8 vertices.
- Start(type 7); 3 vertices; End -> Bad_Type=1, Fifo_Level 0. Then Start(LINES) with 3 vertices; End -> one line; the third vertex is dropped.
- Draw with 2 queued and Ready=0 for 3 cycles -> outputs stable. Assert RESET mid-drain -> Prim_Valid=0 immediately, Fifo_Level=0, Collecting=0.
